// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
// Holds the PC source select codes and the controller state enum.
package pipe_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_VEC = 2'b10;
  localparam logic [1:0] PCSEL_EPC = 2'b11;

  typedef enum logic {
    ST_RUN,
    ST_VECTOR
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Ports: req (N lines) -> valid (any set), idx (winning index).
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/pipe_irq_ctrl.sv
// Pipeline stall/flush sequencer with interrupt entry and ERET.
// Ports: hazard inputs, irq lines/mask in; PC and pipe-reg controls, epc/cause/ie out.
module pipe_irq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                 PC_BITS    = 32,
  parameter int                 IRQ_N      = 4,
  parameter logic [PC_BITS-1:0] VEC_BASE   = 'h0000_0800,
  parameter logic [PC_BITS-1:0] VEC_STRIDE = 'h0000_0020
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_busy,
  input  logic                       branch_taken,
  input  logic                       eret,
  input  logic                       load_use,
  input  logic                       id_valid,
  input  logic [PC_BITS-1:0]         id_pc,
  input  logic [IRQ_N-1:0]           irq_req,
  input  logic [IRQ_N-1:0]           irq_mask,
  output logic                       pc_en,
  output logic [1:0]                 pc_sel,
  output logic [PC_BITS-1:0]         pc_vec,
  output logic                       if_id_en,
  output logic                       id_ex_en,
  output logic                       if_id_clr,
  output logic                       id_ex_clr,
  output logic                       ex_mem_clr,
  output logic [PC_BITS-1:0]         epc,
  output logic [$clog2(IRQ_N)-1:0]   cause,
  output logic                       ie
);

  localparam int CW = $clog2(IRQ_N);

  state_t           state;
  state_t           state_nx;
  logic [IRQ_N-1:0] pend;
  logic [IRQ_N-1:0] acc_mask;
  logic             win_valid;
  logic [CW-1:0]    win_idx;
  logic             accept;
  logic             eret_go;

  irq_prio_enc #(
    .N (IRQ_N),
    .W (CW)
  ) u_enc (
    .req   (pend & irq_mask),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign pc_vec = VEC_BASE + PC_BITS'(cause) * VEC_STRIDE;

  always_comb begin
    pc_en      = 1'b1;
    pc_sel     = PCSEL_SEQ;
    if_id_en   = 1'b1;
    id_ex_en   = 1'b1;
    if_id_clr  = 1'b0;
    id_ex_clr  = 1'b0;
    ex_mem_clr = 1'b0;
    accept     = 1'b0;
    eret_go    = 1'b0;
    acc_mask   = '0;
    state_nx   = state;
    if (rst) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      if_id_clr  = 1'b1;
      id_ex_clr  = 1'b1;
      ex_mem_clr = 1'b1;
      state_nx   = ST_RUN;
    end else if (state == ST_VECTOR) begin
      // EX holds a bubble here, so hazard inputs are ignored.
      pc_sel    = PCSEL_VEC;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
      state_nx  = ST_RUN;
    end else if (ex_busy) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_clr = 1'b1;
    end else if (branch_taken) begin
      pc_sel    = PCSEL_BR;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else if (eret) begin
      pc_sel    = PCSEL_EPC;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
      eret_go   = 1'b1;
    end else if (load_use) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_clr = 1'b1;
    end else if (ie && win_valid && id_valid) begin
      // The ID instruction is squashed and becomes the return point.
      pc_en             = 1'b0;
      if_id_clr         = 1'b1;
      id_ex_clr         = 1'b1;
      accept            = 1'b1;
      acc_mask[win_idx] = 1'b1;
      state_nx          = ST_VECTOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pend  <= '0;
      epc   <= '0;
      cause <= '0;
      ie    <= 1'b1;
    end else begin
      state <= state_nx;
      pend  <= (pend | irq_req) & ~acc_mask;
      if (accept) begin
        epc   <= id_pc;
        cause <= win_idx;
        ie    <= 1'b0;
      end else if (eret_go) begin
        ie <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_irq_ctrl.md
# pipe_irq_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It owns the PC enable and PC-source select, and it drives the load-enable and clear inputs of the IF/ID, ID/EX and EX/MEM registers. It resolves multi-cycle EX stalls, taken branches, ERET, load-use hazards and external interrupt entry into one consistent set of stall/flush controls. It also holds the interrupt state: pending, global enable, EPC and cause.

## Interface
- PC_BITS, 32, PC width
- IRQ_N, 4, number of interrupt lines; line 0 has the highest priority
- VEC_BASE, 32'h0000_0800, handler address for line 0
- VEC_STRIDE, 32'h0000_0020, address step per line
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_busy  in  1  multi-cycle operation in EX has not finished
- branch_taken  in  1  EX resolved a taken branch or jump
- eret  in  1  ERET is in EX
- load_use  in  1  ID reads a register loaded by the instruction in EX
- id_valid  in  1  ID holds a real instruction, not a bubble
- id_pc  in  PC_BITS  PC of the instruction in ID
- irq_req  in  IRQ_N  level interrupt lines
- irq_mask  in  IRQ_N  per-line enable; 1 = enabled
- pc_en  out  1  PC register load enable
- pc_sel  out  2  PC source: 00 = seq, 01 = branch, 10 = vector, 11 = EPC
- pc_vec  out  PC_BITS  handler address, valid when pc_sel = 10
- if_id_en, id_ex_en  out  1 each  register load enables; 1 = load
- if_id_clr, id_ex_clr, ex_mem_clr  out  1 each  synchronous zero; clear dominates enable
- epc  out  PC_BITS  return address
- cause  out  clog2(IRQ_N)  index of the line last taken
- ie  out  1  global interrupt enable

## Operation
- State register values: RUN, VECTOR. All stall/flush outputs are combinational from state and inputs.
- pend register: each cycle pend <= pend | irq_req. When a line is accepted, its bit is cleared in that cycle; the clear wins over the set.
- Eligible lines = pend & irq_mask. The winner is the lowest eligible index.
- **RUN state.** The first matching rule applies. Unlisted enables are 1 and unlisted clears are 0.
  1. ex_busy: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_clr=1.
  2. branch_taken: pc_en=1, pc_sel=01, if_id_clr=1, id_ex_clr=1.
  3. eret: pc_sel=11, pc_en=1, if_id_clr=1, id_ex_clr=1. ie <= 1.
  4. load_use: pc_en=0, if_id_en=0, id_ex_clr=1.
  5. Accept an interrupt when ie && |eligible && id_valid:
     - outputs: pc_en=0, if_id_clr=1, id_ex_clr=1
     - updates: epc <= id_pc, cause <= k, ie <= 0, pend[k] <= 0
     - next state: VECTOR
  6. Otherwise normal flow: pc_sel=00, everything enabled.
- **VECTOR state.**
  - pc_en=1, pc_sel=10, pc_vec = VEC_BASE + k*VEC_STRIDE using the registered cause.
  - if_id_clr=1, id_ex_clr=1.
  - Next state: RUN.
  - ex_busy, branch_taken, eret and load_use are ignored. EX holds a bubble in this cycle, so none of them can be legitimately asserted.
- Arithmetic: pc_vec is computed modulo 2^PC_BITS, and the multiply is done at PC_BITS width.

## Timing
- Interrupt latency:
  - A line asserted at edge N is in pend after edge N.
  - It is accepted in the next eligible RUN cycle.
  - The vector is loaded into the PC at the end of the following VECTOR cycle. The handler's first fetch is 2 cycles after acceptance.
- Branch and ERET redirect take effect in the same cycle; exactly 2 instructions are squashed.
- Simultaneous events:
  - An interrupt is never accepted in a cycle where rules 1–4 fire, or while id_valid=0. It waits.
  - Because EPC is always the PC of a real ID instruction, no return address is lost.
- Reset:
  - While rst=1: pc_en=0, if_id_clr=id_ex_clr=ex_mem_clr=1, enables 0.
  - After the reset edge: state=RUN, pend=0, epc=0, cause=0, ie=1.
  - rst takes priority in any state, including VECTOR; the pending redirect is abandoned.
- A line deasserted after being latched stays pending until accepted.

## Structure
- Package pipe_ctrl_pkg: pc_sel encodings (PCSEL_SEQ, PCSEL_BR, PCSEL_VEC, PCSEL_EPC) and the state enum.
- Sub-module irq_prio_enc: an IRQ_N-wide fixed-priority encoder that outputs a valid bit and an index.

## Test plan
- ex_busy=1 for 3 cycles with load_use=1: pc_en=0, if_id_en=0, id_ex_en=0 and ex_mem_clr=1 for all 3 cycles. Once ex_busy drops, the load_use stall applies: id_ex_clr=1 for 1 cycle.
- branch_taken=1 and irq_req=0001 in the same cycle: pc_sel=01, both clears asserted, interrupt not accepted. Next cycle with id_valid=1 it is accepted: epc=id_pc, cause=0.
- irq_req=1010, irq_mask=1111, ie=1, id_pc=32'h0040_0010: cause=1 and epc=32'h0040_0010. Next cycle pc_vec=32'h0000_0820, pc_sel=10. pend then equals 1000 and ie=0.
- irq_mask=0000 with irq_req=0100: never accepted. Setting irq_mask=0100 later gives acceptance with cause=2.
- eret after a handler: pc_sel=11 with pc=epc and ie=1. A still-pending line 3 is accepted on the next valid RUN cycle.
- rst asserted during VECTOR: state returns to RUN, no vector load occurs, and all outputs take their reset values.
